// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared decode constants and control-word layout for pipelined_control.
// Control word (24 bits, MSB first):
//   {RW, Alu[1:0], Enable_Offset, Mux_Alu_In, Mux_Alu_Out, Mux_WB, WR, Hab_MUL, Rs[4:0], Rt[4:0], Rd[4:0]}
package ctrl_pkg;
    localparam int CTRL_W = 24;
    localparam logic [5:0] OP_R    = 6'd17;
    localparam logic [5:0] OP_LW   = 6'd18;
    localparam logic [5:0] OP_SW   = 6'd19;
    localparam logic [4:0] SHAMT_R = 5'd10;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_MUL  = 6'd50;
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;
    localparam int B_RW  = 23;
    localparam int B_ALU = 21;
    localparam int B_EO  = 20;
    localparam int B_MAI = 19;
    localparam int B_MAO = 18;
    localparam int B_MWB = 17;
    localparam int B_WR  = 16;
    localparam int B_MUL = 15;
    localparam int B_RS  = 10;
    localparam int B_RT  = 5;
    localparam int B_RD  = 0;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational instruction decode into the 24-bit control word.
// Ports: instr_i (instruction), ctrl_o (control word), illegal_o (undecodable),
//        mul_o (legal MUL), src_a_o/src_b_o (source registers that can create
//        a dependency; 0 when the slot is unused).
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]       instr_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              illegal_o,
    output logic              mul_o,
    output logic [4:0]        src_a_o,
    output logic [4:0]        src_b_o
);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic       r_ok, r_alu, r_legal, lw, sw, mem;
    logic [1:0] alu;

    assign op      = instr_i[31:26];
    assign rs      = instr_i[25:21];
    assign rt      = instr_i[20:16];
    assign rd      = instr_i[15:11];
    assign fn      = instr_i[5:0];
    assign r_ok    = (op == OP_R) && (instr_i[10:6] == SHAMT_R);
    assign r_alu   = r_ok && (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR});
    assign mul_o   = r_ok && (fn == FN_MUL);
    assign r_legal = r_alu || mul_o;
    assign lw      = (op == OP_LW);
    assign sw      = (op == OP_SW);
    assign mem     = lw || sw;
    assign alu     = (fn == FN_SUB) ? ALU_SUB : (fn == FN_AND) ? ALU_AND : (fn == FN_OR) ? ALU_OR : ALU_ADD;

    assign illegal_o = !(r_legal || mem);
    // Illegal instructions carry no dependency; Rt is only read by R-type and SW.
    assign src_a_o = illegal_o ? 5'd0 : rs;
    assign src_b_o = (r_legal || sw) ? rt : 5'd0;

    always_comb begin
        ctrl_o              = '0;
        ctrl_o[B_RW]        = lw || r_legal;
        ctrl_o[B_ALU +: 2]  = r_alu ? alu : ALU_ADD;
        ctrl_o[B_EO]        = mem;
        ctrl_o[B_MAI]       = mem;
        ctrl_o[B_MAO]       = !mul_o;
        ctrl_o[B_MWB]       = mem;
        ctrl_o[B_WR]        = sw;
        ctrl_o[B_MUL]       = mul_o;
        ctrl_o[B_RS +: 5]   = rs;
        ctrl_o[B_RT +: 5]   = rt;
        ctrl_o[B_RD +: 5]   = lw ? rt : r_legal ? rd : 5'd0;
    end
endmodule

// File: rtl/pipelined_control.sv
// pipelined_control: registered decode into the ID/EX boundary with load-use
// and MUL interlocks and a saturating bubble counter.
// Ports: clk/rst (sync active-high), instr/instr_valid/instr_ready (fetch side),
//        ex_stall (execute back-pressure), ctrl/ctrl_valid/illegal (issued word),
//        mul_busy (multiplier occupancy), bubble_count (hazard bubbles).
module pipelined_control
    import ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 3,
    parameter bit EN_HAZARD = 1'b1,
    parameter int BCNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic              ex_stall,
    output logic [CTRL_W-1:0] ctrl,
    output logic              ctrl_valid,
    output logic              illegal,
    output logic              mul_busy,
    output logic [BCNT_W-1:0] bubble_count
);
    localparam int MW = $clog2(MUL_LAT + 1);

    logic [CTRL_W-1:0] dec_ctrl, ctrl_q, ctrl_d;
    logic              dec_illegal, dec_mul;
    logic [4:0]        src_a, src_b, lw_rd, mul_rd_q, mul_rd_d;
    logic              valid_q, valid_d, illegal_q, illegal_d;
    logic [MW-1:0]     mul_cnt_q, mul_cnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              load_use, mul_hz, hazard, accept, mul_issue;

    ctrl_decode u_dec (
        .instr_i   (instr),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal),
        .mul_o     (dec_mul),
        .src_a_o   (src_a),
        .src_b_o   (src_b)
    );

    // The held word is an LW exactly when RW and Enable_Offset are both set.
    assign lw_rd     = ctrl_q[B_RD +: 5];
    assign load_use  = valid_q && ctrl_q[B_RW] && ctrl_q[B_EO] && (lw_rd != 5'd0) &&
                       ((src_a == lw_rd) || (src_b == lw_rd));
    assign mul_hz    = (mul_cnt_q != '0) &&
                       (dec_mul || ((mul_rd_q != 5'd0) && ((src_a == mul_rd_q) || (src_b == mul_rd_q))));
    assign hazard    = EN_HAZARD && instr_valid && (load_use || mul_hz);
    assign instr_ready = !ex_stall && !hazard;
    assign accept    = instr_valid && instr_ready;
    assign mul_issue = accept && dec_mul;

    assign ctrl_d    = ex_stall ? ctrl_q : accept ? dec_ctrl : '0;
    assign valid_d   = ex_stall ? valid_q : accept;
    assign illegal_d = ex_stall ? illegal_q : accept && dec_illegal;
    assign mul_cnt_d = mul_issue ? MW'(MUL_LAT - 1) :
                       (!ex_stall && (mul_cnt_q != '0)) ? mul_cnt_q - MW'(1) : mul_cnt_q;
    assign mul_rd_d  = mul_issue ? dec_ctrl[B_RD +: 5] : mul_rd_q;
    assign bcnt_d    = (hazard && !ex_stall && !(&bcnt_q)) ? bcnt_q + BCNT_W'(1) : bcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            mul_cnt_q <= '0;
            mul_rd_q  <= 5'd0;
            bcnt_q    <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            mul_cnt_q <= mul_cnt_d;
            mul_rd_q  <= mul_rd_d;
            bcnt_q    <= bcnt_d;
        end
    end

    assign ctrl         = ctrl_q;
    assign ctrl_valid   = valid_q;
    assign illegal      = illegal_q;
    assign mul_busy     = (mul_cnt_q != '0);
    assign bubble_count = bcnt_q;
endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipelined_control;
    localparam logic [31:0] I_ADD3 = 32'h44221AA0;
    localparam logic [31:0] I_LW5  = 32'h48250004;
    localparam logic [31:0] I_ADD6 = 32'h44A232A0;
    localparam logic [31:0] I_MUL7 = 32'h44223AB2;
    localparam logic [31:0] I_ADD8 = 32'h44E142A0;

    logic        clk = 1'b0;
    logic        rst, instr_valid, ex_stall;
    logic [31:0] instr;
    logic        instr_ready, ctrl_valid, illegal, mul_busy;
    logic [23:0] ctrl;
    logic [3:0]  bubble_count;
    logic        n_ready, n_valid, n_illegal, n_busy;
    logic [23:0] n_ctrl;
    logic [15:0] n_bcnt;
    int          total = 0, bad = 0;

    typedef struct packed {
        logic [23:0] c;
        logic        ill, mul, lw;
        logic [4:0]  sa, sb, rd;
    } dec_t;

    pipelined_control #(.MUL_LAT(3), .EN_HAZARD(1'b1), .BCNT_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ex_stall(ex_stall), .ctrl(ctrl), .ctrl_valid(ctrl_valid), .illegal(illegal),
        .mul_busy(mul_busy), .bubble_count(bubble_count)
    );

    pipelined_control #(.MUL_LAT(3), .EN_HAZARD(1'b0), .BCNT_W(16)) dut_nh (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(n_ready),
        .ex_stall(ex_stall), .ctrl(n_ctrl), .ctrl_valid(n_valid), .illegal(n_illegal),
        .mul_busy(n_busy), .bubble_count(n_bcnt)
    );

    always #5 clk = ~clk;

    // Reference decode written straight from the instruction table.
    function automatic dec_t mdec(input logic [31:0] i);
        dec_t d;
        logic [5:0] op = i[31:26];
        logic [5:0] fn = i[5:0];
        logic [4:0] rs = i[25:21];
        logic [4:0] rt = i[20:16];
        logic       r  = op == 6'd17 && i[10:6] == 5'd10 &&
                         (fn == 6'd32 || fn == 6'd34 || fn == 6'd36 || fn == 6'd37 || fn == 6'd50);
        logic       lw = op == 6'd18;
        logic       sw = op == 6'd19;
        logic [1:0] alu = fn == 6'd34 ? 2'd1 : fn == 6'd36 ? 2'd2 : fn == 6'd37 ? 2'd3 : 2'd0;
        d.ill = !(r || lw || sw);
        d.mul = r && fn == 6'd50;
        d.lw  = lw;
        d.sa  = d.ill ? 5'd0 : rs;
        d.sb  = (r || sw) ? rt : 5'd0;
        d.rd  = lw ? rt : r ? i[15:11] : 5'd0;
        d.c   = {r || lw, (r && !d.mul) ? alu : 2'd0, lw || sw, lw || sw, !d.mul, lw || sw, sw, d.mul, rs, rt, d.rd};
        return d;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] x = $urandom;
        logic [5:0]  fns [4] = '{6'd32, 6'd34, 6'd36, 6'd37};
        int k = $urandom_range(0, 7);
        x[25:21] = 5'($urandom_range(0, 3));
        x[20:16] = 5'($urandom_range(0, 3));
        x[15:11] = 5'($urandom_range(0, 3));
        if (k <= 4) begin
            x[31:26] = 6'd17;
            x[10:6]  = 5'd10;
            x[5:0]   = (k == 4) ? 6'd50 : fns[k];
        end else if (k == 5) x[31:26] = 6'd18;
        else if (k == 6) x[31:26] = 6'd19;
        else if ($urandom_range(0, 1) == 1) x[31:26] = 6'($urandom_range(20, 63));
        else x[31:26] = 6'd17;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic [31:0] i);
        rst = r;
        instr_valid = v;
        ex_stall = s;
        instr = i;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0);
        tick();
        tick();
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 1, I_ADD3);
        tick();
        tick();
        total++; if (ctrl !== 24'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", ctrl); end
        total++; if (ctrl_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ctrl_valid); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", mul_busy); end
        total++; if (bubble_count !== 4'd0) begin bad++; $display("FAIL reset_bcnt got=%0d exp=0", bubble_count); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_add();
        do_reset();
        drive(0, 1, 0, I_ADD3);
        #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b exp=1", instr_ready); end
        tick();
        total++; if (ctrl !== 24'h840443) begin bad++; $display("FAIL add_ctrl got=%h exp=840443", ctrl); end
        total++; if (ctrl_valid !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL add_flags got=%b%b exp=10", ctrl_valid, illegal); end
        drive(0, 0, 0, 0);
        tick();
        total++; if (ctrl_valid !== 1'b0 || ctrl !== 24'h0) begin bad++; $display("FAIL add_bubble got=%b/%h exp=0/0", ctrl_valid, ctrl); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(0, 1, 0, I_LW5);
        tick();
        total++; if (ctrl !== 24'h9E04A5) begin bad++; $display("FAIL lw_ctrl got=%h exp=9e04a5", ctrl); end
        drive(0, 1, 0, I_ADD6);
        #1;
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL lu_ready got=%b exp=0", instr_ready); end
        total++; if (n_ready !== 1'b1) begin bad++; $display("FAIL lu_nh_ready got=%b exp=1", n_ready); end
        tick();
        total++; if (ctrl_valid !== 1'b0 || bubble_count !== 4'd1) begin bad++; $display("FAIL lu_bubble got=%b/%0d exp=0/1", ctrl_valid, bubble_count); end
        total++; if (n_ctrl !== 24'h841446 || n_valid !== 1'b1) begin bad++; $display("FAIL lu_nh_issue got=%h/%b exp=841446/1", n_ctrl, n_valid); end
        #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL lu_ready2 got=%b exp=1", instr_ready); end
        tick();
        total++; if (ctrl !== 24'h841446 || ctrl_valid !== 1'b1) begin bad++; $display("FAIL lu_issue got=%h/%b exp=841446/1", ctrl, ctrl_valid); end
        total++; if (bubble_count !== 4'd1) begin bad++; $display("FAIL lu_bcnt got=%0d exp=1", bubble_count); end
        total++; if (n_bcnt !== 16'd0) begin bad++; $display("FAIL lu_nh_bcnt got=%0d exp=0", n_bcnt); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_mul();
        do_reset();
        drive(0, 1, 0, I_MUL7);
        tick();
        total++; if (ctrl !== 24'h808447) begin bad++; $display("FAIL mul_ctrl got=%h exp=808447", ctrl); end
        total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL mul_busy1 got=%b exp=1", mul_busy); end
        drive(0, 1, 0, I_ADD8);
        for (int k = 1; k <= 2; k++) begin
            #1;
            total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL mul_ready%0d got=%b exp=0", k, instr_ready); end
            tick();
            total++; if (ctrl_valid !== 1'b0 || bubble_count !== 4'(k)) begin bad++; $display("FAIL mul_bubble%0d got=%b/%0d exp=0/%0d", k, ctrl_valid, bubble_count, k); end
            total++; if (mul_busy !== (k == 1)) begin bad++; $display("FAIL mul_busy_w%0d got=%b exp=%b", k, mul_busy, k == 1); end
        end
        tick();
        total++; if (ctrl !== 24'h841C28 || ctrl_valid !== 1'b1) begin bad++; $display("FAIL mul_dep_issue got=%h/%b exp=841c28/1", ctrl, ctrl_valid); end
        total++; if (bubble_count !== 4'd2) begin bad++; $display("FAIL mul_bcnt got=%0d exp=2", bubble_count); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_illegal();
        do_reset();
        drive(0, 1, 0, 32'hFC000000);
        tick();
        total++; if (ctrl !== 24'h040000 || ctrl_valid !== 1'b1 || illegal !== 1'b1) begin bad++; $display("FAIL ill_op got=%h/%b/%b exp=040000/1/1", ctrl, ctrl_valid, illegal); end
        drive(0, 1, 0, 32'h44221820);
        tick();
        total++; if (ctrl !== 24'h040440 || illegal !== 1'b1) begin bad++; $display("FAIL ill_shamt got=%h/%b exp=040440/1", ctrl, illegal); end
        drive(0, 0, 0, 0);
        tick();
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b exp=0", illegal); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(0, 1, 0, I_MUL7);
        tick();
        drive(0, 1, 0, I_LW5);
        tick();
        drive(0, 1, 1, I_ADD6);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL st_ready%0d got=%b exp=0", k, instr_ready); end
            tick();
            total++; if (ctrl !== 24'h9E04A5 || ctrl_valid !== 1'b1) begin bad++; $display("FAIL st_hold%0d got=%h/%b exp=9e04a5/1", k, ctrl, ctrl_valid); end
            total++; if (mul_busy !== 1'b1 || bubble_count !== 4'd0) begin bad++; $display("FAIL st_cnt%0d got=%b/%0d exp=1/0", k, mul_busy, bubble_count); end
        end
        drive(0, 1, 0, I_ADD6);
        tick();
        total++; if (ctrl_valid !== 1'b0 || bubble_count !== 4'd1 || mul_busy !== 1'b0) begin bad++; $display("FAIL st_resume got=%b/%0d/%b exp=0/1/0", ctrl_valid, bubble_count, mul_busy); end
        tick();
        total++; if (ctrl !== 24'h841446) begin bad++; $display("FAIL st_issue got=%h exp=841446", ctrl); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1, 0, I_MUL7);
        tick();
        drive(1, 1, 1, I_ADD8);
        tick();
        total++; if (ctrl !== 24'h0 || ctrl_valid !== 1'b0 || mul_busy !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL rm_clear got=%h/%b/%b/%b exp=0/0/0/0", ctrl, ctrl_valid, mul_busy, illegal); end
        drive(0, 1, 0, I_ADD8);
        #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b exp=1", instr_ready); end
        tick();
        total++; if (ctrl !== 24'h841C28 || ctrl_valid !== 1'b1) begin bad++; $display("FAIL rm_issue got=%h/%b exp=841c28/1", ctrl, ctrl_valid); end
        drive(0, 0, 0, 0);
    endtask

    task automatic test_random();
        dec_t        d;
        logic        r, v, s, ld, mh, hz, rdy;
        logic        m_valid = 0, m_ill = 0, m_lw = 0;
        logic [23:0] m_ctrl = 0;
        logic [4:0]  m_rd = 0, m_mrd = 0;
        int          m_left = 0, m_bc = 0;
        logic [31:0] i;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99) == 0;
            v = $urandom_range(0, 3) != 0;
            s = $urandom_range(0, 4) == 0;
            i = rnd_instr();
            drive(r, v, s, i);
            #1;
            d   = mdec(i);
            ld  = m_valid && m_lw && m_rd != 0 && (d.sa == m_rd || d.sb == m_rd);
            mh  = m_left > 0 && (d.mul || (m_mrd != 0 && (d.sa == m_mrd || d.sb == m_mrd)));
            hz  = v && (ld || mh);
            rdy = !s && !hz;
            if (!r) begin
                total++; if (instr_ready !== rdy) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, instr_ready, rdy); end
            end
            if (r) begin
                m_valid = 0; m_ill = 0; m_lw = 0; m_ctrl = 0; m_rd = 0; m_mrd = 0; m_left = 0; m_bc = 0;
            end else if (!s) begin
                if (hz) m_bc = (m_bc == 15) ? 15 : m_bc + 1;
                if (v && rdy && d.mul) begin
                    m_left = 2;
                    m_mrd = d.rd;
                end else if (m_left > 0) m_left--;
                m_valid = v && rdy;
                m_ctrl  = m_valid ? d.c : 24'h0;
                m_ill   = m_valid && d.ill;
                m_lw    = m_valid && d.lw;
                m_rd    = m_valid ? d.rd : 5'd0;
            end
            tick();
            total++; if (ctrl !== m_ctrl) begin bad++; $display("FAIL rnd_ctrl n=%0d got=%h exp=%h", n, ctrl, m_ctrl); end
            total++; if (ctrl_valid !== m_valid || illegal !== m_ill) begin bad++; $display("FAIL rnd_flags n=%0d got=%b%b exp=%b%b", n, ctrl_valid, illegal, m_valid, m_ill); end
            total++; if (mul_busy !== (m_left > 0)) begin bad++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, mul_busy, m_left > 0); end
            total++; if (bubble_count !== 4'(m_bc)) begin bad++; $display("FAIL rnd_bcnt n=%0d got=%0d exp=%0d", n, bubble_count, m_bc); end
        end
        drive(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_mul();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
Registered successor to the combinational instruction-decode control unit. It decodes the group-17 R-type, LW (18) and SW (19) instructions into the same 24-bit control word, then registers it into the ID/EX boundary behind a valid/ready handshake. It adds a load-use interlock, a multi-cycle MUL occupancy tracker, illegal-instruction flagging and a bubble counter. It sits between fetch (IF/ID) and the execute stage of the MIPS CPU.

Parameters:
OP_R, 17, opcode of R-type group
OP_LW, 18, opcode of load word
OP_SW, 19, opcode of store word
SHAMT_R, 10, required instr[10:6] for legal R-type
MUL_LAT, 3, multiplier latency in cycles (>=1)
EN_HAZARD, 1, 1 = hardware interlock on; 0 = no interlock (software-scheduled)
BCNT_W, 16, bubble counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
instr  in  32  instruction from IF/ID
instr_valid  in  1  instr is valid
instr_ready  out  1  block accepts instr this cycle (combinational)
ex_stall  in  1  execute stage cannot take a new control word; hold
ctrl  out  24  {RW, Alu[1:0], Enable_Offset, Mux_Alu_In, Mux_Alu_Out, Mux_WB, WR, Hab_MUL, Rs[4:0], Rt[4:0], Rd[4:0]}
ctrl_valid  out  1  ctrl holds an issued instruction
illegal  out  1  issued instruction was undecodable (qualified by ctrl_valid)
mul_busy  out  1  multiplier occupancy window active
bubble_count  out  BCNT_W  saturating count of hazard bubbles

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous and active-high. On reset: ctrl=0, ctrl_valid=0, illegal=0, mul_cnt=0, mul_rd=0, bubble_count=0. Reset overrides everything, including mid-MUL and ex_stall.
- Decode is identical to the existing unit:
  - LW: RW=1, Alu=0, Enable_Offset=1, Mux_Alu_In=1, Mux_Alu_Out=1, Mux_WB=1, WR=0, Rd=Rt.
  - SW: RW=0, Enable_Offset=1, Mux_Alu_In=1, Mux_Alu_Out=1, Mux_WB=1, WR=1, Rd=0.
  - R-type: RW=1, Rd=instr[15:11]. Requires shamt==SHAMT_R. funct 32/34/36/37 -> Alu 0/1/2/3 with Mux_Alu_Out=1; funct 50 -> Hab_MUL=1, Mux_Alu_Out=0.
- Illegal: any other opcode, funct, or shamt. Control fields take the defaults (RW=0, WR=0, Alu=0, Mux_Alu_Out=1, others 0, Rs/Rt from instr, Rd=0) and illegal=1. The instruction still issues with ctrl_valid=1 and has no architectural side effect.
- Accept: instr_valid && instr_ready. instr_ready = !ex_stall && !hazard. Latency is 1 cycle: the decoded word appears on ctrl with ctrl_valid=1 after the accepting edge.
- ex_stall=1: ctrl, ctrl_valid, illegal and mul_cnt all hold; nothing is accepted.
- No accept and ex_stall=0: ctrl<=0, ctrl_valid<=0 (bubble).
- Load-use hazard (EN_HAZARD=1): ctrl_valid && issued is LW && issued Rd!=0 && incoming source matches issued Rd. Incoming sources are Rs for all legal instructions, plus Rt for R-type and SW.
- MUL hazard (EN_HAZARD=1): mul_cnt!=0 and either the incoming instruction is a MUL, or one of its sources equals mul_rd (mul_rd!=0).
- hazard = load-use OR MUL hazard. Hazard is evaluated only when instr_valid=1.
- MUL tracking: issuing a MUL loads mul_cnt<=MUL_LAT-1 and mul_rd<=Rd. mul_cnt decrements by 1 on each edge with ex_stall=0 and mul_cnt!=0. mul_busy = (mul_cnt!=0). MUL_LAT=1 gives no busy window.
- bubble_count: increments by 1 on each edge where instr_valid && hazard && !ex_stall. Both hazards in the same cycle count once. Saturates at all-ones; never wraps.
- EN_HAZARD=0: hazard forced to 0. MUL tracking and mul_busy still operate.
- Register 0 never creates a dependency.

Decomposition:
- Shared package ctrl_pkg:
  - opcode/funct constants (32, 34, 36, 37, 50)
  - CTRL_W=24
  - bit-index localparams for each control field
  - Alu encoding constants (ADD=0, SUB=1, AND=2, OR=3)
- One natural sub-module: ctrl_decode. It is purely combinational (instr -> ctrl word + illegal) and is reused from the existing unit's logic.
- pipelined_control holds the pipeline register, hazard logic, MUL counter and bubble counter.

Test Plan:
- Reset, then ADD r3=r1+r2 (0x44221AA0) with instr_valid=1 -> next cycle ctrl=0x840443, ctrl_valid=1, illegal=0.
- LW r5,4(r1) (0x48250004), then ADD r6=r5+r2 (0x44A232A0) held valid -> ctrl=0x9E04A5. Then one cycle with instr_ready=0 and ctrl_valid=0; bubble_count=1; ADD issues on the following edge. Repeat with EN_HAZARD=0 -> no bubble, bubble_count=0.
- MUL r7=r1*r2 (0x44223AB2), MUL_LAT=3, followed by ADD r8=r7+r1 -> MUL ctrl has Hab_MUL=1, Mux_Alu_Out=0. mul_busy high for 2 cycles, 2 bubbles, ADD issues on the 3rd edge, bubble_count=2.
- Illegal opcode 0xFC000000 -> ctrl_valid=1, illegal=1, RW=0, WR=0. An ADD with shamt=0 is also illegal.
- Issue LW, then assert ex_stall for 3 cycles -> ctrl stays 0x9E04A5, instr_ready=0, mul_cnt and bubble_count unchanged. Deassert -> normal flow resumes.
- Assert rst while mul_busy=1 and ctrl_valid=1 -> next cycle all outputs 0 and mul_busy=0. A dependent instruction is accepted immediately.
